// File: rtl/pcie_tlp_tx_gen.sv
// PCIe TX TLP generator: AXI AW+W bursts become MWr TLPs, AR bursts become MRd TLPs,
// split at MPS/MRRS and 4KB boundaries, with round-robin write/read arbitration.
module pcie_tlp_tx_gen #(
    parameter int          ADDR_WIDTH    = 64,
    parameter int          PAYLOAD_WIDTH = 256,
    parameter int          MPS_BYTES     = 128,
    parameter int          MRRS_BYTES    = 512,
    parameter logic [15:0] REQ_ID        = 16'h0100,
    parameter int          TAG_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     aw_valid,
    output logic                     aw_ready,
    input  logic [ADDR_WIDTH-1:0]    aw_addr,
    input  logic [7:0]               aw_len,
    input  logic                     ar_valid,
    output logic                     ar_ready,
    input  logic [ADDR_WIDTH-1:0]    ar_addr,
    input  logic [7:0]               ar_len,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [PAYLOAD_WIDTH-1:0] w_data,
    input  logic                     w_last,
    output logic                     tlp_valid,
    input  logic                     tlp_ready,
    output logic [PAYLOAD_WIDTH-1:0] tlp_data,
    output logic                     tlp_sop,
    output logic                     tlp_eop,
    output logic                     err_wlast
);

    localparam int BEAT_BYTES = PAYLOAD_WIDTH / 8;
    localparam int BEAT_SH    = $clog2(BEAT_BYTES);
    localparam int BEAT_DW    = BEAT_BYTES / 4;
    localparam logic [8:0] MPS_BEATS  = 9'(MPS_BYTES / BEAT_BYTES);
    localparam logic [8:0] MRRS_BEATS = 9'(MRRS_BYTES / BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(BEAT_BYTES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HDR     = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;

    logic [1:0]            state;
    logic                  alive;
    logic                  aw_pend, ar_pend;
    logic [ADDR_WIDTH-1:0] aw_cur, ar_cur;
    logic [8:0]            aw_rem, ar_rem;
    logic                  last_wr;
    logic [TAG_WIDTH-1:0]  tag_cnt;
    logic [127:0]          hdr_q;
    logic                  cur_rd;
    logic [8:0]            pl_cnt;
    logic                  final_chunk;

    // chunk for the channel that would be granted this cycle
    logic                  grant_rd;
    logic [ADDR_WIDTH-1:0] sel_addr, next_addr;
    logic [8:0]            sel_rem, sel_lim, bnd_beats, chunk_beats, next_rem;
    logic [12:0]           bnd_bytes;
    logic [9:0]            len_dw;
    logic                  is_4dw;
    logic [31:0]           dw0, dw1, dw2, dw3;
    logic                  aw_fire, ar_fire, w_fire, pl_last;

    always_comb begin
        grant_rd    = ar_pend & (~aw_pend | last_wr);
        sel_addr    = grant_rd ? ar_cur : aw_cur;
        sel_rem     = grant_rd ? ar_rem : aw_rem;
        sel_lim     = grant_rd ? MRRS_BEATS : MPS_BEATS;
        bnd_bytes   = 13'd4096 - {1'b0, sel_addr[11:0]};
        bnd_beats   = 9'(bnd_bytes >> BEAT_SH);
        chunk_beats = sel_rem;
        if (sel_lim < chunk_beats)   chunk_beats = sel_lim;
        if (bnd_beats < chunk_beats) chunk_beats = bnd_beats;
        len_dw      = 10'(chunk_beats * BEAT_DW);
        next_addr   = sel_addr + (ADDR_WIDTH'(chunk_beats) << BEAT_SH);
        next_rem    = sel_rem - chunk_beats;
        is_4dw      = |sel_addr[ADDR_WIDTH-1:32];
        dw0         = {1'b0, ~grant_rd, is_4dw, 19'd0, len_dw};
        dw1         = {REQ_ID, grant_rd ? 8'(tag_cnt) : 8'h00, 8'hFF};
        dw2         = is_4dw ? sel_addr[63:32] : sel_addr[31:0];
        dw3         = is_4dw ? sel_addr[31:0] : 32'd0;
    end

    assign aw_ready  = alive & ~aw_pend;
    assign ar_ready  = alive & ~ar_pend;
    assign aw_fire   = aw_valid & aw_ready;
    assign ar_fire   = ar_valid & ar_ready;
    assign pl_last   = (pl_cnt == 9'd1);
    assign w_ready   = (state == PAYLOAD) & tlp_ready;
    assign w_fire    = w_valid & w_ready;
    assign tlp_valid = (state == HDR) | ((state == PAYLOAD) & w_valid);
    assign tlp_sop   = (state == HDR);
    assign tlp_eop   = ((state == HDR) & cur_rd) | ((state == PAYLOAD) & w_valid & pl_last);
    assign tlp_data  = (state == HDR)     ? {{(PAYLOAD_WIDTH-128){1'b0}}, hdr_q} :
                       (state == PAYLOAD) ? w_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            alive       <= 1'b0;
            aw_pend     <= 1'b0;
            ar_pend     <= 1'b0;
            aw_cur      <= '0;
            ar_cur      <= '0;
            aw_rem      <= '0;
            ar_rem      <= '0;
            last_wr     <= 1'b1;
            tag_cnt     <= '0;
            hdr_q       <= '0;
            cur_rd      <= 1'b0;
            pl_cnt      <= '0;
            final_chunk <= 1'b0;
            err_wlast   <= 1'b0;
        end else begin
            alive     <= 1'b1;
            err_wlast <= w_fire & (w_last != (final_chunk & pl_last));
            case (state)
                IDLE: if (aw_pend | ar_pend) begin
                    hdr_q       <= {dw3, dw2, dw1, dw0};
                    cur_rd      <= grant_rd;
                    last_wr     <= ~grant_rd;
                    pl_cnt      <= chunk_beats;
                    final_chunk <= (next_rem == 9'd0);
                    state       <= HDR;
                    // pend drops with the grant of the last chunk, so a new
                    // command can land while that chunk is still being sent
                    if (grant_rd) begin
                        ar_cur <= next_addr;
                        ar_rem <= next_rem;
                        if (next_rem == 9'd0) ar_pend <= 1'b0;
                    end else begin
                        aw_cur <= next_addr;
                        aw_rem <= next_rem;
                        if (next_rem == 9'd0) aw_pend <= 1'b0;
                    end
                end
                HDR: if (tlp_ready) begin
                    if (cur_rd) begin
                        tag_cnt <= tag_cnt + 1'b1;
                        state   <= IDLE;
                    end else begin
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: if (w_fire) begin
                    pl_cnt <= pl_cnt - 9'd1;
                    if (pl_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (aw_fire) begin
                aw_pend <= 1'b1;
                aw_cur  <= aw_addr & ADDR_MASK;
                aw_rem  <= {1'b0, aw_len} + 9'd1;
            end
            if (ar_fire) begin
                ar_pend <= 1'b1;
                ar_cur  <= ar_addr & ADDR_MASK;
                ar_rem  <= {1'b0, ar_len} + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_pcie_tlp_tx_gen.sv
// Directed bench for pcie_tlp_tx_gen: collects accepted TLP beats and checks them
// against hand-computed headers and payloads.
module tb_pcie_tlp_tx_gen;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         aw_valid = 1'b0, ar_valid = 1'b0, w_valid = 1'b0, w_last = 1'b0;
    logic         aw_ready, ar_ready, w_ready;
    logic [63:0]  aw_addr = '0, ar_addr = '0;
    logic [7:0]   aw_len = '0, ar_len = '0;
    logic [255:0] w_data = '0;
    logic         tlp_valid, tlp_ready = 1'b1, tlp_sop, tlp_eop, err_wlast;
    logic [255:0] tlp_data;

    typedef struct {
        logic [255:0] d;
        logic         sop;
        logic         eop;
    } beat_t;

    beat_t q[$];
    int    total = 0, bad = 0, err_cnt = 0;
    bit    rdy_toggle = 1'b0;
    logic         prev_stall = 1'b0;
    logic [257:0] prev_out = '0;

    pcie_tlp_tx_gen dut (
        .clk(clk), .rst_n(rst_n),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_data(tlp_data),
        .tlp_sop(tlp_sop), .tlp_eop(tlp_eop), .err_wlast(err_wlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // output monitor: capture accepted beats, verify stability under backpressure
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && tlp_valid)
                chk("hold", {tlp_sop, tlp_eop, tlp_data}, prev_out);
            if (tlp_valid && tlp_ready) q.push_back('{tlp_data, tlp_sop, tlp_eop});
            if (err_wlast) err_cnt++;
            prev_stall = tlp_valid & ~tlp_ready;
            prev_out   = {tlp_sop, tlp_eop, tlp_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        tlp_ready = rdy_toggle ? ~tlp_ready : 1'b1;
    end

    task automatic send_aw(input logic [63:0] a, input logic [7:0] l);
        bit ok = 0;
        @(posedge clk); #1;
        aw_valid = 1'b1; aw_addr = a; aw_len = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (aw_ready) begin ok = 1; break; end
        end
        if (!ok) chk("aw_timeout", 0, 1);
        @(posedge clk); #1;
        aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [63:0] a, input logic [7:0] l);
        bit ok = 0;
        @(posedge clk); #1;
        ar_valid = 1'b1; ar_addr = a; ar_len = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ar_ready) begin ok = 1; break; end
        end
        if (!ok) chk("ar_timeout", 0, 1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
    endtask

    // bad_last puts w_last on the first beat instead of the last one
    task automatic send_w(input int n, input logic [255:0] base, input bit bad_last);
        for (int i = 0; i < n; i++) begin
            bit ok = 0;
            @(posedge clk); #1;
            w_valid = 1'b1;
            w_data  = base + 256'(i);
            w_last  = bad_last ? (i == 0) : (i == n - 1);
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (w_ready) begin ok = 1; break; end
            end
            if (!ok) chk("w_timeout", 0, 1);
        end
        @(posedge clk); #1;
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 400 && q.size() < n; i++) @(negedge clk);
        chk("beat_count", 256'(q.size()), 256'(n));
    endtask

    task automatic chk_hdr(input string tag, input int idx, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3, input logic eop);
        beat_t b;
        if (idx >= q.size()) begin
            chk({tag, "_missing"}, 0, 1);
            return;
        end
        b = q[idx];
        chk({tag, "_hdr"}, {b.d[255:128], b.d[127:96], b.d[95:64], b.d[63:32], b.d[31:0]},
            {128'd0, e3, e2, e1, e0});
        chk({tag, "_sop_eop"}, {b.sop, b.eop}, {1'b1, eop});
    endtask

    task automatic chk_pl(input string tag, input int idx, input logic [255:0] d, input logic eop);
        if (idx >= q.size()) begin
            chk({tag, "_missing"}, 0, 1);
            return;
        end
        chk({tag, "_pl"}, {q[idx].sop, q[idx].eop, q[idx].d}, {1'b0, eop, d});
    endtask

    localparam logic [255:0] D1 = {8{32'hA5A5_0001}};
    localparam logic [255:0] D3 = {8{32'h3300_0000}};
    localparam logic [255:0] D5 = {8{32'h5500_0000}};
    localparam logic [255:0] D7 = {8{32'h7700_0000}};

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_outs", {aw_ready, ar_ready, w_ready, tlp_valid, tlp_sop, tlp_eop, err_wlast}, 0);
        chk("rst_data", tlp_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ready_up", {aw_ready, ar_ready}, 2'b11);

        // 1: single-beat MWr, 3DW
        fork send_aw(64'h1100, 8'd0); send_w(1, D1, 0); join
        wait_beats(2);
        chk_hdr("t1", 0, 32'h4000_0008, 32'h0100_00FF, 32'h0000_1100, 32'h0, 1'b0);
        chk_pl("t1", 1, D1, 1'b1);
        q.delete();

        // 2: 4DW MRd then 3DW MRd, tags 0 and 1
        send_ar(64'h1_0000_2000, 8'd0);
        wait_beats(1);
        chk_hdr("t2a", 0, 32'h2000_0008, 32'h0100_00FF, 32'h0000_0001, 32'h0000_2000, 1'b1);
        q.delete();
        send_ar(64'h3000, 8'd0);
        wait_beats(1);
        chk_hdr("t2b", 0, 32'h0000_0008, 32'h0100_01FF, 32'h0000_3000, 32'h0, 1'b1);
        q.delete();

        // 3: 256B write split at MPS into two 32DW MWr
        fork send_aw(64'h2000, 8'd7); send_w(8, D3, 0); join
        wait_beats(10);
        chk_hdr("t3a", 0, 32'h4000_0020, 32'h0100_00FF, 32'h0000_2000, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) chk_pl("t3a", 1 + i, D3 + 256'(i), i == 3);
        chk_hdr("t3b", 5, 32'h4000_0020, 32'h0100_00FF, 32'h0000_2080, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) chk_pl("t3b", 6 + i, D3 + 256'(4 + i), i == 3);
        chk("t3_err", 256'(err_cnt), 0);
        q.delete();

        // 4: read crossing 4KB boundary
        send_ar(64'hFE0, 8'd1);
        wait_beats(2);
        chk_hdr("t4a", 0, 32'h0000_0008, 32'h0100_02FF, 32'h0000_0FE0, 32'h0, 1'b1);
        chk_hdr("t4b", 1, 32'h0000_0008, 32'h0100_03FF, 32'h0000_1000, 32'h0, 1'b1);
        q.delete();

        // 5: both channels pending, toggled backpressure; last grant was read
        rdy_toggle = 1'b1;
        fork send_aw(64'h4000, 8'd7); send_ar(64'h5000, 8'd31); send_w(8, D5, 0); join
        wait_beats(12);
        chk_hdr("t5w0", 0, 32'h4000_0020, 32'h0100_00FF, 32'h0000_4000, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) chk_pl("t5w0", 1 + i, D5 + 256'(i), i == 3);
        chk_hdr("t5r0", 5, 32'h0000_0080, 32'h0100_04FF, 32'h0000_5000, 32'h0, 1'b1);
        chk_hdr("t5w1", 6, 32'h4000_0020, 32'h0100_00FF, 32'h0000_4080, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) chk_pl("t5w1", 7 + i, D5 + 256'(4 + i), i == 3);
        chk_hdr("t5r1", 11, 32'h0000_0080, 32'h0100_05FF, 32'h0000_5200, 32'h0, 1'b1);
        rdy_toggle = 1'b0;
        repeat (2) @(posedge clk);
        q.delete();

        // 6: reset during second payload beat
        send_aw(64'h6000, 8'd3);
        @(posedge clk); #1;
        w_valid = 1'b1; w_data = D7; w_last = 1'b0;
        for (int k = 0; k < 200 && !w_ready; k++) @(negedge clk);
        chk("t6_beat0", w_ready, 1'b1);
        @(posedge clk); #1;
        w_data = D7 + 256'd1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_outs", {aw_ready, ar_ready, w_ready, tlp_valid, tlp_sop, tlp_eop, err_wlast}, 0);
        chk("t6_rst_data", tlp_data, 0);
        w_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete();
        err_cnt = 0;
        fork send_aw(64'h7000, 8'd0); send_w(1, D7, 0); join
        wait_beats(2);
        chk_hdr("t6w", 0, 32'h4000_0008, 32'h0100_00FF, 32'h0000_7000, 32'h0, 1'b0);
        chk_pl("t6w", 1, D7, 1'b1);
        q.delete();
        send_ar(64'h8000, 8'd0);
        wait_beats(1);
        chk_hdr("t6r", 0, 32'h0000_0008, 32'h0100_00FF, 32'h0000_8000, 32'h0, 1'b1);
        q.delete();

        // 7: misplaced w_last on a 2-beat burst flags both beats
        fork send_aw(64'h9000, 8'd1); send_w(2, D1, 1); join
        wait_beats(3);
        repeat (3) @(negedge clk);
        chk("t7_err", 256'(err_cnt), 2);
        chk_pl("t7", 2, D1 + 256'd1, 1'b1);
        q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
